// File: rtl/mux_4_1_rr_arbiter.sv
// Four-requester round-robin arbiter feeding one registered 4:1 mux stage (optional burst priority: RR_BURST_EN).
// Latency 1 cycle input handshake to out_valid; in_ready drops to 0 while the output stage is stalled.
module mux_4_1_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_burst_len_check
        $error("BURST_LEN must be in 1..15");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    logic [1:0]         last_grant;
    logic [1:0]         start;
    logic [1:0]         gidx;
    logic [1:0]         cand;
    logic               found;
    logic [3:0]         grant;
    logic               load_en;
    logic               xfer;
    logic [WIDTH-1:0]   sel_dat;

    assign load_en = (state == EMPTY) || out_ready;
    assign xfer    = load_en && (|in_valid);

`ifdef RR_BURST_EN
    logic [3:0] burst_cnt;
    logic       hold_prio;

    // The current winner stays at the head of the search until its burst is used up or it stops asking.
    assign hold_prio = (burst_cnt != 4'd0) && (burst_cnt < 4'(BURST_LEN)) && in_valid[last_grant];
    assign start     = hold_prio ? last_grant : last_grant + 2'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            burst_cnt <= 4'd0;
        end else if (xfer) begin
            if (gidx != last_grant)
                burst_cnt <= 4'd1;
            else if (burst_cnt < 4'(BURST_LEN))
                burst_cnt <= burst_cnt + 4'd1;
        end
    end
`else
    assign start = last_grant + 2'd1;
`endif

    always_comb begin
        grant = 4'b0000;
        gidx  = start;
        cand  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!found && in_valid[cand]) begin
                found       = 1'b1;
                gidx        = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign in_ready = load_en ? grant : 4'b0000;

    always_comb begin
        case (gidx)
            2'd0:    sel_dat = a;
            2'd1:    sel_dat = b;
            2'd2:    sel_dat = c;
            default: sel_dat = d;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_sel    <= 2'd0;
            last_grant <= 2'd3;
        end else if (xfer) begin
            state      <= FULL;
            out_data   <= sel_dat;
            out_sel    <= gidx;
            last_grant <= gidx;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed self-checking bench for mux_4_1_rr_arbiter.
module tb_mux_4_1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] in_valid = 4'b0000;
    logic [3:0] a = 4'd4;
    logic [3:0] b = 4'd1;
    logic [3:0] c = 4'd9;
    logic [3:0] d = 4'd3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int checks   = 0;
    int failures = 0;

    logic [3:0] dat [4];
    logic [6:0] obs7;
    logic [6:0] exp7;

    always #5 clk = ~clk;

    mux_4_1_rr_arbiter #(.WIDTH(4), .BURST_LEN(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sel  (out_sel)
    );

    function automatic logic [6:0] beat(input logic v, input int s);
        logic [1:0] s2;
        s2 = 2'(s);
        return {v, s2, dat[s]};
    endfunction

    task automatic reset_dut();
        rstn      = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        obs7 = {out_valid, out_sel, out_data};
        checks++;
        if (obs7 !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs7, 7'd0);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        release_reset();
    endtask

    task automatic test_rotation();
        int sels [5] = '{0, 1, 2, 3, 0};
        reset_dut();
        release_reset();
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rot_first_ready: got %b expected 0001", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            exp7 = beat(1'b1, sels[i]);
            obs7 = {out_valid, out_sel, out_data};
            checks++;
            if (obs7 !== exp7) begin
                failures++;
                $display("FAIL rot_beat%0d: got %b expected %b", i, obs7, exp7);
            end
            checks++;
            if (in_ready !== (4'b0001 << ((sels[i] + 1) % 4))) begin
                failures++;
                $display("FAIL rot_ready%0d: got %b expected %b", i, in_ready,
                         4'b0001 << ((sels[i] + 1) % 4));
            end
        end
    endtask

    task automatic test_single_requester();
        reset_dut();
        release_reset();
        in_valid = 4'b0100;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_ready%0d: got %b expected 0100", i, in_ready);
            end
            @(posedge clk);
            #1;
            obs7 = {out_valid, out_sel, out_data};
            checks++;
            if (obs7 !== beat(1'b1, 2)) begin
                failures++;
                $display("FAIL single_beat%0d: got %b expected %b", i, obs7, beat(1'b1, 2));
            end
        end
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
        obs7 = {out_valid, out_sel, out_data};
        checks++;
        if (obs7 !== beat(1'b0, 2)) begin
            failures++;
            $display("FAIL single_drain: got %b expected %b", obs7, beat(1'b0, 2));
        end
    endtask

    task automatic test_stall();
        reset_dut();
        release_reset();
        in_valid = 4'b1111;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL stall_ready%0d: got %b expected 0000", i, in_ready);
            end
            @(posedge clk);
            #1;
            obs7 = {out_valid, out_sel, out_data};
            checks++;
            if (obs7 !== beat(1'b1, 0)) begin
                failures++;
                $display("FAIL stall_hold%0d: got %b expected %b", i, obs7, beat(1'b1, 0));
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++;
            $display("FAIL stall_release_ready: got %b expected 0010", in_ready);
        end
        @(posedge clk);
        #1;
        obs7 = {out_valid, out_sel, out_data};
        checks++;
        if (obs7 !== beat(1'b1, 1)) begin
            failures++;
            $display("FAIL stall_release_beat: got %b expected %b", obs7, beat(1'b1, 1));
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        release_reset();
        in_valid = 4'b0100;
        @(posedge clk);
        #1;
        obs7 = {out_valid, out_sel, out_data};
        checks++;
        if (obs7 !== beat(1'b1, 2)) begin
            failures++;
            $display("FAIL midrst_loaded: got %b expected %b", obs7, beat(1'b1, 2));
        end
        rstn = 1'b0;
        #1;
        obs7 = {out_valid, out_sel, out_data};
        checks++;
        if (obs7 !== 7'd0) begin
            failures++;
            $display("FAIL midrst_async_clear: got %b expected %b", obs7, 7'd0);
        end
        rstn     = 1'b1;
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_first_ready: got %b expected 0001", in_ready);
        end
        @(posedge clk);
        #1;
        obs7 = {out_valid, out_sel, out_data};
        checks++;
        if (obs7 !== beat(1'b1, 0)) begin
            failures++;
            $display("FAIL midrst_first_beat: got %b expected %b", obs7, beat(1'b1, 0));
        end
    endtask

    task automatic test_two_requesters();
        int sels [4] = '{0, 3, 0, 3};
        reset_dut();
        release_reset();
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ((in_ready & 4'b0110) !== 4'b0000) begin
                failures++;
                $display("FAIL pair_ready%0d: got %b expected no grant to 1 or 2", i, in_ready);
            end
            @(posedge clk);
            #1;
            obs7 = {out_valid, out_sel, out_data};
            checks++;
            if (obs7 !== beat(1'b1, sels[i])) begin
                failures++;
                $display("FAIL pair_beat%0d: got %b expected %b", i, obs7, beat(1'b1, sels[i]));
            end
        end
    endtask

    task automatic test_burst_sequence();
`ifdef RR_BURST_EN
        int sels [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
`else
        int sels [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif
        reset_dut();
        release_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            obs7 = {out_valid, out_sel, out_data};
            checks++;
            if (obs7 !== beat(1'b1, sels[i])) begin
                failures++;
                $display("FAIL burst_beat%0d: got %b expected %b", i, obs7, beat(1'b1, sels[i]));
            end
        end
    endtask

    initial begin
        dat[0] = 4'd4;
        dat[1] = 4'd1;
        dat[2] = 4'd9;
        dat[3] = 4'd3;
        test_reset();
        test_rotation();
        test_single_requester();
        test_stall();
        test_mid_reset();
        test_two_requesters();
        test_burst_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
